// File: rtl/cnn_frame_sequencer.sv
// Frame sequencer for the pixel-stream CNN pipeline: feeds one IMG_W x IMG_H frame,
// tags pixels whose 3x3 window is interior and re-aligns those tags with the results.
module cnn_frame_sequencer #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int PIPE_LAT = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic signed [DATA_W-1:0] src_data,
    output logic                     pix_valid,
    output logic signed [DATA_W-1:0] pix_data,
    input  logic                     res_valid,
    input  logic signed [DATA_W-1:0] res_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);
    localparam int CNT_W = $clog2(N_OUT + 1);
    localparam int DRN_W = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t              state;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    col;
    logic [CNT_W-1:0]    out_cnt;
    logic [DRN_W-1:0]    drain_cnt;
    logic [PIPE_LAT-1:0] tags;
    logic                accept;
    logic                keep;
    logic                tag_out;

    assign src_ready = (state == FEED);
    assign accept    = src_valid & src_ready;
    assign pix_valid = accept;
    assign pix_data  = src_data;
    assign busy      = (state == FEED) || (state == DRAIN);
    assign done      = (state == DONE);
    assign keep      = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign tag_out   = tags[PIPE_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            out_cnt   <= '0;
            drain_cnt <= '0;
            tags      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            drain_cnt <= '0;
            tags      <= '0;
            out_valid <= 1'b0;
        end else begin
            // Tags travel alongside the pipeline, so they shift even on source gaps.
            tags      <= (tags << 1) | PIPE_LAT'(keep);
            out_valid <= tag_out & res_valid;
            if (tag_out) out_data <= res_data;
            if (out_valid) out_cnt <= out_cnt + CNT_W'(1);
            if (tag_out && !res_valid) err <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FEED;
                        row     <= '0;
                        col     <= '0;
                        out_cnt <= '0;
                        err     <= 1'b0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        if (col == COL_W'(IMG_W - 1)) begin
                            col <= '0;
                            if (row == ROW_W'(IMG_H - 1)) begin
                                row       <= '0;
                                state     <= DRAIN;
                                drain_cnt <= DRN_W'(PIPE_LAT);
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) state <= DONE;
                    else drain_cnt <= drain_cnt - DRN_W'(1);
                end
                DONE: begin
                    state <= IDLE;
                    if (out_cnt != CNT_W'(N_OUT)) err <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Scoreboard bench for cnn_frame_sequencer: a behavioural pipeline model feeds results
// back, expected interior results are queued at accept time and popped by a monitor.
module tb_cnn_frame_sequencer;

    localparam int DW   = 8;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int L    = 6;
    localparam int NPIX = W * H;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready, pix_valid, res_valid, out_valid, busy, done, err;
    logic [DW-1:0] pix_data, res_data, out_data;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   out_seen = 0;
    int   drop_cyc = -100;
    exp_t exp_q[$];

    logic [L-1:0]  pv = '0;
    logic [DW-1:0] pd [L];
    int            pc [L];

    cnn_frame_sequencer #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .PIPE_LAT(L)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .res_valid(res_valid), .res_data(res_data),
        .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] model_res(input logic [DW-1:0] p);
        return DW'(p * 5 + 1);
    endfunction

    // Behavioural pipeline: a fixed L-cycle delay line applying model_res.
    always @(posedge clk) begin
        for (int i = L - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
            pc[i] <= pc[i-1];
        end
        pv[0] <= pix_valid;
        pd[0] <= pix_data;
        pc[0] <= cyc;
    end
    assign res_valid = pv[L-1] && (pc[L-1] != drop_cyc);
    assign res_data  = model_res(pd[L-1]);

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic expv);
        chk(name, int'(act), int'(expv));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (out_valid) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(out_data), int'(e.data));
                    chk("out_cycle", cyc, e.due + 1);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (drop_cyc >= 0 && cyc == drop_cyc + L) chk1("err_before_drop", err, 1'b0);
            if (drop_cyc >= 0 && cyc == drop_cyc + L + 1) chk1("err_after_drop", err, 1'b1);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, "_src_ready"}, src_ready, 1'b0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic run_frame(input bit gaps, input bit rnd, input int drop_k, input int abort_k,
                             input bit poke, input bit rst_drain, input logic exp_err);
        int   k = 0;
        int   t = 0;
        int   w = 0;
        int   last_acc = 0;
        int   n_exp = 0;
        bit   aborted = 0;
        exp_t e;
        done_cnt = 0;
        out_seen = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk1("busy_after_start", busy, 1'b1);
        chk1("err_cleared", err, 1'b0);
        @(posedge clk); #1;
        while (k < NPIX && t < 1000) begin
            src_valid = !gaps || (t % 2 == 0);
            src_data  = rnd ? DW'($urandom) : DW'(k);
            abort     = (k == abort_k) && src_valid;
            start     = poke && (t == 10);
            @(negedge clk);
            if (abort) begin
                // Results whose pipeline slot is at or after the abort cycle never appear.
                aborted = 1;
                while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= cyc) begin
                    exp_q.delete(exp_q.size() - 1);
                    n_exp--;
                end
                @(posedge clk); #1;
                abort = 1'b0;
                break;
            end
            if (src_valid && src_ready) begin
                if (k / W >= 2 && k % W >= 2 && k != drop_k) begin
                    e.data = model_res(src_data);
                    e.due  = cyc + L;
                    exp_q.push_back(e);
                    n_exp++;
                end
                if (k == drop_k) drop_cyc = cyc;
                last_acc = cyc;
                k++;
            end
            @(posedge clk); #1;
            t++;
        end
        src_valid = 1'b0;
        start     = 1'b0;
        if (aborted) begin
            @(negedge clk);
            chk1("abort_src_ready", src_ready, 1'b0);
            chk1("abort_busy", busy, 1'b0);
            repeat (L + 4) @(negedge clk);
            chk("abort_no_done", done_cnt, 0);
        end else begin
            chk("accepts", k, NPIX);
            @(negedge clk);
            chk1("drain_src_ready", src_ready, 1'b0);
            chk1("drain_busy", busy, 1'b1);
            if (poke) begin
                @(posedge clk); #1 start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
            end
            if (rst_drain) begin
                @(posedge clk); #3 rst = 1'b0;
                #1 chk_reset_outputs("async_rst");
                n_exp = n_exp - exp_q.size();
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                repeat (L + 4) @(negedge clk);
                chk1("post_rst_src_ready", src_ready, 1'b0);
                chk1("post_rst_busy", busy, 1'b0);
                chk("post_rst_no_done", done_cnt, 0);
            end else begin
                while (!done && w < 40) begin
                    @(negedge clk);
                    w++;
                end
                chk1("done_seen", done, 1'b1);
                chk("done_latency", cyc - last_acc, L + 2);
                chk1("done_busy", busy, 1'b0);
                chk1("done_err", err, exp_err);
                repeat (4) @(negedge clk);
                chk("done_pulses", done_cnt, 1);
                chk1("idle_err", err, exp_err);
                chk1("idle_src_ready", src_ready, 1'b0);
            end
        end
        chk("out_count", out_seen, n_exp);
        chk("queue_empty", exp_q.size(), 0);
        drop_cyc = -100;
    endtask

    initial begin
        #3 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        run_frame(0, 0, -1, -1, 0, 0, 1'b0);
        run_frame(1, 1, -1, -1, 0, 0, 1'b0);
        run_frame(0, 1, 3 * W + 4, -1, 0, 0, 1'b1);
        run_frame(0, 1, -1, 30, 0, 0, 1'b0);
        run_frame(0, 1, -1, -1, 0, 0, 1'b0);
        run_frame(1, 1, -1, -1, 1, 0, 1'b0);
        run_frame(0, 1, -1, -1, 0, 1, 1'b0);
        run_frame(0, 1, -1, -1, 0, 0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
Frame-level controller for the pixel-stream CNN pipeline (linebuffer -> conv -> batchnorm -> leaky ReLU). On a start command it pulls exactly IMG_W*IMG_H pixels from a ready/valid source and feeds them to the pipeline. It tracks row and column position and tags each pixel whose 3x3 window lies fully inside the image. It re-aligns those tags with the pipeline results to emit only interior results, checks result alignment, and signals frame completion after the pipeline has drained.

Parameters:
DATA_W, 8, pixel and result width (signed)
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in rows (>=3)
PIPE_LAT, 6, cycles from a pixel-accept cycle to the cycle its result_valid is high (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  begin a frame; sampled only in IDLE
abort  in  1  cancel the current frame; any state
src_valid  in  1  source pixel valid
src_ready  out  1  sequencer ready for a pixel
src_data  in  DATA_W  source pixel (signed)
pix_valid  out  1  pixel strobe to the pipeline (in_valid)
pix_data  out  DATA_W  pixel to the pipeline
res_valid  in  1  pipeline result valid
res_data  in  DATA_W  pipeline result (signed)
out_valid  out  1  interior result valid
out_data  out  DATA_W  interior result
busy  out  1  high in FEED or DRAIN
done  out  1  one-cycle completion pulse
err  out  1  sticky alignment-error flag

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; row, col, out_cnt and drain_cnt = 0; tag shift register all 0. Outputs: out_valid=0, out_data=0, done=0, err=0, busy=0, src_ready=0.
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: when start=1 and abort=0, go to FEED; clear row, col, out_cnt and err.
- FEED:
  - src_ready=1 (combinational from state).
  - A pixel is accepted in any cycle with src_valid=1 and src_ready=1.
  - pix_valid = accept; pix_data = src_data (combinational pass-through, zero added latency).
  - Gaps (src_valid=0) are legal; counters hold during a gap.
  - On accept: col increments. At col=IMG_W-1, col wraps to 0 and row increments.
  - On accept of row=IMG_H-1, col=IMG_W-1: go to DRAIN with drain_cnt=PIPE_LAT.
- DRAIN:
  - src_ready=0.
  - If drain_cnt=0, go to DONE; otherwise decrement drain_cnt.
- DONE: done=1 for exactly one cycle, then go to IDLE. busy=0 in this state.
- Tag path:
  - keep = accept AND row>=2 AND col>=2, using pre-increment row and col.
  - The tag shift register is PIPE_LAT deep. It shifts every cycle, including gaps; keep enters at stage 0.
  - tag_out = last stage.
- Output (registered):
  - out_valid <= tag_out AND res_valid; out_data <= res_data when tag_out=1, else hold.
  - out_cnt increments on each out_valid.
- Error detection: err is set (sticky until the next start) on tag_out=1 with res_valid=0. It is also set if, in the DONE cycle, out_cnt != (IMG_W-2)*(IMG_H-2).
- Timing from the final accept cycle A:
  - last out_valid is visible at A+PIPE_LAT+1.
  - done is visible at A+PIPE_LAT+2.
- start outside IDLE is ignored.
- abort=1 (priority over all other events): next state IDLE. row, col, drain_cnt and tags are cleared. out_valid=0. done is not pulsed. err holds.
- An accept coinciding with abort does not advance the counters. pix_valid still reflects the combinational accept that cycle.
- Reset asserted mid-frame gives the full reset values immediately (asynchronous).
- Counter widths: row and col use clog2 of the respective dimension; out_cnt must hold (IMG_W-2)*(IMG_H-2).

Test Plan:
1. Default params, start, src_valid held 1 with pixels 0..63 -> 64 accepts, src_ready low after the 64th; exactly 36 out_valid pulses (windows ending at rows 2..7, cols 2..7); done single pulse at A+8; err=0; busy high from cycle after start through DRAIN.
2. Same frame with src_valid toggling 1,0,1,0 -> still 64 accepts and 36 out_valid; out_valid pulses spaced as the accepts; done at last accept+8.
3. Pipeline model whose res_valid is dropped for one tagged result -> err rises the cycle after; out_cnt=35; err stays 1 through DONE and IDLE; clears on the next start.
4. abort during pixel 30 of FEED -> IDLE next cycle, src_ready=0, no done pulse; a subsequent start runs a clean full frame (36 outputs, err=0).
5. start pulsed during FEED and DRAIN -> ignored: no counter reset, single done.
6. Assert rst=0 asynchronously (between edges) in DRAIN -> all outputs at reset values immediately; after release, IDLE; src_ready=0 until start.
